spi_mul_master: RTL and testbench
=================================

SPI_MUL_MASTER -- requirements
Module: spi_mul_master

Interface
REQ-001 Parameter: CLK_DIV, default 2, sclk half-period in clock cycles; SHALL be >= 1.
REQ-002 Parameter: GAP_CYCLES, default 8, nss-high cycles between transmit and receive phases; SHALL be >= 1.
REQ-003 clock  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  operation request valid.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_opcode  in  3  operation code, forwarded unmodified.
REQ-008 req_opa  in  32  operand A.
REQ-009 req_opb  in  32  operand B.
REQ-010 rsp_valid  out  1  result valid.
REQ-011 rsp_ready  in  1  consumer accepts result.
REQ-012 rsp_data  out  32  result word.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 nss  out  1  active-low slave select.
REQ-015 sclk  out  1  serial clock, idle low.
REQ-016 mosi  out  1  serial data to slave.
REQ-017 miso  in  1  serial data from slave.

Function
REQ-018 States: IDLE, TX, GAP, RX, DONE; only these SHALL be reachable.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-020 On accept, a 67-bit frame {opcode, opa, opb} SHALL be latched; later req_* changes SHALL have no effect.
REQ-021 TX: nss low from the cycle after accept; 67 bits shifted MSB first (bit 66 = opcode[2]).
REQ-022 Each bit period: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; mosi SHALL change only at the start of a low half.
REQ-023 After the 67th high half: sclk low, nss high, enter GAP for exactly GAP_CYCLES cycles.
REQ-024 RX: nss low; 32 bit periods, same timing as TX; miso sampled on the clock edge where sclk rises, MSB first into rsp_data[31:0].
REQ-025 mosi SHALL be 0 outside TX.
REQ-026 After the 32nd high half: nss high, sclk low, enter DONE with rsp_valid = 1.
REQ-027 rsp_valid SHALL rise exactly 198*CLK_DIV + GAP_CYCLES + 1 cycles after the accept edge (405 at defaults).
REQ-028 DONE: rsp_valid and rsp_data SHALL hold until rsp_ready; on rsp_valid && rsp_ready, return to IDLE next cycle.
REQ-029 rsp_ready already high on DONE entry: rsp_valid high for exactly one cycle.
REQ-030 req_valid outside IDLE SHALL be ignored; no queuing.
REQ-031 rsp_data SHALL keep the last result until the next RX overwrites it.
REQ-032 Bit and divider counters SHALL wrap only via explicit reload; no arithmetic overflow is permitted.

Reset
REQ-033 Reset asserted in any state: IDLE immediately; nss=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1 after release.
REQ-034 Reset mid-frame SHALL abort the transfer with no partial rsp_valid.

Structure
REQ-035 Package spi_mul_pkg SHALL hold the state enum, FRAME_BITS=67, RESULT_BITS=32, OPCODE_BITS=3.
REQ-036 One sub-module spi_sclk_gen SHALL generate sclk plus one-cycle rise/fall strobes from CLK_DIV, enabled by the FSM.

Verification
REQ-037 Defaults, opcode=3'b010, opa=32'h0000_0003, opb=32'h0000_0007; slave model returns 32'h0000_0015 -> mosi stream equals frame 67'h2_0000_0003_0000_0007, rsp_data=32'h15, rsp_valid at cycle 405.
REQ-038 CLK_DIV=1, GAP_CYCLES=1, opa=opb=32'hFFFF_FFFF, miso returns 32'hFFFF_FFFE -> sclk period 2 cycles, gap nss high exactly 1 cycle, rsp_data=32'hFFFF_FFFE.
REQ-039 rsp_ready held low 20 cycles after rsp_valid -> rsp_valid/rsp_data stable 20 cycles; req_valid pulses during that time ignored.
REQ-040 Reset asserted at bit 30 of TX -> nss=1, sclk=0 asynchronously; new request after release produces a complete, correct frame.
REQ-041 Back-to-back requests with rsp_ready tied high -> second accept exactly 2 cycles after first rsp_valid rise; both results correct.

Source files
------------

// File: rtl/spi_mul_pkg.sv
// Shared types and frame geometry for the SPI multiply master.
// The request frame is {opcode, opa, opb} and the result is a single word.
package spi_mul_pkg;

    localparam int OPCODE_BITS  = 3;
    localparam int OPERAND_BITS = 32;
    localparam int FRAME_BITS   = 67;
    localparam int RESULT_BITS  = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX   = 3'd1,
        GAP  = 3'd2,
        RX   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock generator: idle-low sclk with CLK_DIV-cycle halves while enabled.
// rise/fall are high in the cycle whose closing edge moves sclk up/down.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          half_end;

    assign half_end = en && (div_cnt == DIV_LAST);
    assign rise     = half_end && !sclk;
    assign fall     = half_end && sclk;

    // Disabling the generator parks it at the start of a low half.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/spi_mul_master.sv
// SPI master that ships a 67-bit {opcode, opa, opb} frame to a multiplier slave,
// waits a fixed nss-high gap, then reads back a 32-bit result.
// Handshakes: a transfer moves on a rising clock edge where valid && ready;
// valid holds its payload until that edge, and ready never depends on valid.
module spi_mul_master
    import spi_mul_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPCODE_BITS-1:0] req_opcode,
    input  logic [31:0]            req_opa,
    input  logic [31:0]            req_opb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RESULT_BITS-1:0] rsp_data,
    output logic                   busy,
    output logic                   nss,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output state_t                 dbg_state
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [6:0] TX_LAST = 7'(FRAME_BITS - 1);
    localparam logic [6:0] RX_LAST = 7'(RESULT_BITS - 1);

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  frame;
    logic [6:0]             bit_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   rx_lead;
    logic [RESULT_BITS-1:0] rx_shift;
    logic                   sclk_en, sclk_rise, sclk_fall;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clock (clock),
        .reset (reset),
        .en    (sclk_en),
        .sclk  (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // rx_lead gives the slave one extra cycle of nss-low setup before the
    // first RX bit period starts.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        nss       = 1'b1;
        mosi      = 1'b0;
        sclk_en   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = TX;
            end
            TX: begin
                nss     = 1'b0;
                mosi    = frame[FRAME_BITS-1];
                sclk_en = 1'b1;
                if (sclk_fall && bit_cnt == TX_LAST) state_d = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_d = RX;
            end
            RX: begin
                nss     = 1'b0;
                sclk_en = !rx_lead;
                if (sclk_fall && bit_cnt == RX_LAST) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            rx_lead  <= 1'b0;
            rx_shift <= '0;
            rsp_data <= '0;
        end else begin
            rx_lead <= (state_q == GAP);
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        frame   <= {req_opcode, req_opa, req_opb};
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end
                TX: begin
                    // Shift at the end of each high half so mosi moves only
                    // as the next low half begins.
                    if (sclk_fall) begin
                        frame   <= {frame[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= (bit_cnt == TX_LAST) ? '0 : bit_cnt + 7'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GW'(1);
                end
                RX: begin
                    if (sclk_rise) rx_shift <= {rx_shift[RESULT_BITS-2:0], miso};
                    if (sclk_fall) begin
                        if (bit_cnt == RX_LAST) begin
                            bit_cnt  <= '0;
                            rsp_data <= rx_shift;
                        end else begin
                            bit_cnt <= bit_cnt + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_mul_master.sv
// Bench for spi_mul_master: a default-parameter instance driven from a vector
// table and corner sequences, plus a CLK_DIV=1/GAP_CYCLES=1 instance.
module tb_spi_mul_master;
    import spi_mul_pkg::*;

    localparam int D  = 2;
    localparam int G  = 8;
    localparam int FD = 1;
    localparam int FG = 1;

    logic clock, reset;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, busy, nss, sclk, mosi, miso;
    logic [2:0]  req_opcode;
    logic [31:0] req_opa, req_opb, rsp_data;
    state_t      dbg_state;

    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_busy, f_nss, f_sclk, f_mosi, f_miso;
    logic [2:0]  f_req_opcode;
    logic [31:0] f_req_opa, f_req_opb, f_rsp_data;
    state_t      f_dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [66:0] exp_frame_q[$];

    spi_mul_master #(.CLK_DIV(D), .GAP_CYCLES(G)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_opa(req_opa), .req_opb(req_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .nss(nss), .sclk(sclk), .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
    );

    spi_mul_master #(.CLK_DIV(FD), .GAP_CYCLES(FG)) u_dut_fast (
        .clock(clock), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_opcode(f_req_opcode), .req_opa(f_req_opa), .req_opb(f_req_opb),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .busy(f_busy),
        .nss(f_nss), .sclk(f_sclk), .mosi(f_mosi), .miso(f_miso), .dbg_state(f_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- slave models ----------------
    // seg: 0 idle, 1 transmit frame (incl. gap), 2 receive frame.
    logic [66:0] s_mosi;
    logic [31:0] s_resp;
    int          s_tx_bits, s_rx_bits, s_seg, s_bad;
    logic        s_sclk_q, s_nss_q, s_mosi_q;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            s_seg <= 0; s_tx_bits <= 0; s_rx_bits <= 0;
            s_sclk_q <= 1'b0; s_nss_q <= 1'b1; s_mosi_q <= 1'b0;
        end else begin
            if (s_nss_q && !nss) begin
                if (s_seg == 0) begin s_seg <= 1; s_tx_bits <= 0; end
                else begin s_seg <= 2; s_rx_bits <= 0; end
            end else if (!s_nss_q && nss && s_seg == 2) begin
                s_seg <= 0;
            end
            if (!nss && sclk && !s_sclk_q) begin
                if (s_seg == 1) begin s_mosi <= {s_mosi[65:0], mosi}; s_tx_bits <= s_tx_bits + 1; end
                else if (s_seg == 2) s_rx_bits <= s_rx_bits + 1;
            end
            if ((mosi && (nss || s_seg == 2)) ||
                (mosi != s_mosi_q && !s_nss_q && !(s_sclk_q && !sclk)))
                s_bad <= s_bad + 1;
            s_sclk_q <= sclk; s_nss_q <= nss; s_mosi_q <= mosi;
        end
    end
    assign miso = (s_seg == 2 && s_rx_bits < 32) ? s_resp[5'(31 - s_rx_bits)] : 1'b0;

    logic [66:0] f_s_mosi;
    logic [31:0] f_s_resp;
    int          f_tx_bits, f_rx_bits, f_seg, f_bad, f_last_rise, f_per_min, f_per_max, f_gap_hi;
    logic        f_sclk_q, f_nss_q, f_mosi_q;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            f_seg <= 0; f_tx_bits <= 0; f_rx_bits <= 0; f_gap_hi <= 0;
            f_sclk_q <= 1'b0; f_nss_q <= 1'b1; f_mosi_q <= 1'b0;
        end else begin
            if (f_nss_q && !f_nss) begin
                if (f_seg == 0) begin f_seg <= 1; f_tx_bits <= 0; f_gap_hi <= 0; end
                else begin f_seg <= 2; f_rx_bits <= 0; end
            end else if (!f_nss_q && f_nss && f_seg == 2) begin
                f_seg <= 0;
            end
            if (f_seg == 1 && f_nss) f_gap_hi <= f_gap_hi + 1;
            if (!f_nss && f_sclk && !f_sclk_q) begin
                if (f_seg == 1) begin
                    f_s_mosi  <= {f_s_mosi[65:0], f_mosi};
                    f_tx_bits <= f_tx_bits + 1;
                    if (f_tx_bits > 0 && cyc - f_last_rise < f_per_min) f_per_min <= cyc - f_last_rise;
                    if (f_tx_bits > 0 && cyc - f_last_rise > f_per_max) f_per_max <= cyc - f_last_rise;
                    f_last_rise <= cyc;
                end else if (f_seg == 2) f_rx_bits <= f_rx_bits + 1;
            end
            if ((f_mosi && (f_nss || f_seg == 2)) ||
                (f_mosi != f_mosi_q && !f_nss_q && !(f_sclk_q && !f_sclk)))
                f_bad <= f_bad + 1;
            f_sclk_q <= f_sclk; f_nss_q <= f_nss; f_mosi_q <= f_mosi;
        end
    end
    assign f_miso = (f_seg == 2 && f_rx_bits < 32) ? f_s_resp[5'(31 - f_rx_bits)] : 1'b0;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        int t = 0;
        while (!rsp_valid && t < 3000) begin @(negedge clock); t++; end
        ok = rsp_valid;
        if (!ok) check("rsp_valid_timeout", 67'd0, 67'd1);
    endtask

    // Drive one request and pop the scoreboard when the result is handed over.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] resp, input logic [66:0] frame, input int hold);
        int t = 0;
        int a0;
        bit ok;
        while (!req_ready && t < 3000) begin @(negedge clock); t++; end
        check("req_ready_before_op", {66'd0, req_ready}, 67'd1);
        s_resp = resp;
        req_opcode = op; req_opa = a; req_opb = b; req_valid = 1'b1;
        exp_q.push_back(resp);
        exp_frame_q.push_back(frame);
        @(posedge clock); #1;
        a0 = cyc;
        req_valid = 1'b0;
        req_opcode = 3'($urandom_range(0, 7)); req_opa = $urandom; req_opb = $urandom;
        @(negedge clock);
        check("busy_in_tx", {66'd0, busy}, 67'd1);
        wait_rsp(ok);
        if (!ok) return;
        check("latency", 67'(cyc - a0), 67'(198 * D + G + 1));
        check("mosi_frame", s_mosi, exp_frame_q.pop_front());
        check("tx_bit_count", 67'(s_tx_bits), 67'd67);
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 4 == 1);
            @(negedge clock);
            check("hold_valid", {66'd0, rsp_valid}, 67'd1);
            check("hold_data", {35'd0, rsp_data}, {35'd0, resp});
        end
        req_valid = 1'b0;
        check("rsp_data", {35'd0, rsp_data}, {35'd0, exp_q.pop_front()});
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        check("idle_after_rsp", {63'd0, rsp_valid, busy, req_ready, 1'b0}, 67'b0010);
        check("rsp_data_kept", {35'd0, rsp_data}, {35'd0, resp});
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, resp;
        logic [66:0] frame;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int a0, r0, t;
        bit ok;
        vecs[0] = '{3'b010, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 67'h2_0000_0003_0000_0007, 0};
        vecs[1] = '{3'b111, 32'hDEAD_BEEF, 32'h0123_4567, 32'hA5A5_5A5A, 67'h7_DEAD_BEEF_0123_4567, 3};
        vecs[2] = '{3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 67'h0, 1};
        vecs[3] = '{3'b100, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 67'h4_8000_0001_FFFF_FFFF, 20};
        for (int i = 4; i < 6; i++) begin
            vecs[i].op = 3'($urandom_range(0, 7));
            vecs[i].a = $urandom; vecs[i].b = $urandom; vecs[i].resp = $urandom;
            vecs[i].frame = {vecs[i].op, vecs[i].a, vecs[i].b};
            vecs[i].hold = $urandom_range(0, 5);
        end

        reset = 1'b0;
        req_valid = 1'b0; req_opcode = '0; req_opa = '0; req_opb = '0; rsp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_opcode = '0; f_req_opa = '0; f_req_opb = '0; f_rsp_ready = 1'b0;
        s_resp = '0; f_s_resp = '0; s_bad = 0; f_bad = 0;
        f_last_rise = 0; f_per_min = 1000; f_per_max = 0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {58'd0, nss, sclk, mosi, rsp_valid, busy, req_ready, 3'd0}, {58'd0, 9'b100001000});
        check("reset_state", {64'd0, dbg_state}, {64'd0, IDLE});
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_reset_outputs", {58'd0, nss, sclk, mosi, rsp_valid, busy, req_ready, 3'd0}, {58'd0, 9'b100001000});
        check("post_reset_rsp_data", {35'd0, rsp_data}, 67'd0);

        // Fast instance: CLK_DIV=1, GAP_CYCLES=1, rsp_ready already high.
        f_s_resp = 32'hFFFF_FFFE;
        f_rsp_ready = 1'b1;
        f_req_opcode = 3'b101; f_req_opa = 32'hFFFF_FFFF; f_req_opb = 32'hFFFF_FFFF; f_req_valid = 1'b1;
        @(posedge clock); #1;
        a0 = cyc;
        f_req_valid = 1'b0; f_req_opa = '0; f_req_opb = '0;
        t = 0;
        while (!f_rsp_valid && t < 3000) begin @(negedge clock); t++; end
        check("fast_rsp_seen", {66'd0, f_rsp_valid}, 67'd1);
        check("fast_latency", 67'(cyc - a0), 67'(198 * FD + FG + 1));
        check("fast_rsp_data", {35'd0, f_rsp_data}, {35'd0, 32'hFFFF_FFFE});
        check("fast_mosi_frame", f_s_mosi, 67'h5_FFFF_FFFF_FFFF_FFFF);
        check("fast_sclk_period_min", 67'(f_per_min), 67'd2);
        check("fast_sclk_period_max", 67'(f_per_max), 67'd2);
        check("fast_gap_nss_high", 67'(f_gap_hi), 67'd1);
        @(negedge clock);
        check("fast_one_cycle_valid", {65'd0, f_rsp_valid, f_req_ready}, 67'b01);
        f_rsp_ready = 1'b0;

        // Vector table on the default instance.
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].frame, vecs[i].hold);

        // Back-to-back with rsp_ready tied high and req_valid held.
        rsp_ready = 1'b1;
        s_resp = 32'h1357_9BDF;
        req_opcode = 3'b011; req_opa = 32'h0000_1111; req_opb = 32'h2222_0000; req_valid = 1'b1;
        exp_q.push_back(32'h1357_9BDF); exp_frame_q.push_back(67'h3_0000_1111_2222_0000);
        exp_q.push_back(32'h0ACE_0BD1); exp_frame_q.push_back(67'h6_1234_5678_9ABC_DEF0);
        @(posedge clock); #1;
        req_opcode = 3'b110; req_opa = 32'h1234_5678; req_opb = 32'h9ABC_DEF0;
        wait_rsp(ok);
        r0 = cyc;
        check("b2b_first_data", {35'd0, rsp_data}, {35'd0, exp_q.pop_front()});
        check("b2b_first_frame", s_mosi, exp_frame_q.pop_front());
        s_resp = 32'h0ACE_0BD1;
        t = 0;
        @(negedge clock);
        while (!(req_valid && req_ready) && t < 50) begin @(negedge clock); t++; end
        @(posedge clock); #1;
        check("b2b_second_accept", 67'(cyc - r0), 67'd2);
        req_valid = 1'b0;
        wait_rsp(ok);
        check("b2b_second_data", {35'd0, rsp_data}, {35'd0, exp_q.pop_front()});
        check("b2b_second_frame", s_mosi, exp_frame_q.pop_front());
        @(negedge clock);
        check("b2b_one_cycle_valid", {66'd0, rsp_valid}, 67'd0);
        rsp_ready = 1'b0;

        // Reset in the middle of the transmit frame.
        s_resp = 32'hFFFF_0000;
        req_opcode = 3'b001; req_opa = 32'h5555_5555; req_opb = 32'hAAAA_AAAA; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        t = 0;
        while (s_tx_bits < 30 && t < 1000) begin @(negedge clock); t++; end
        check("reached_bit_30", {66'd0, s_tx_bits >= 30}, 67'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {58'd0, nss, sclk, mosi, rsp_valid, busy, req_ready, 3'd0}, {58'd0, 9'b100001000});
        check("async_reset_rsp_data", {35'd0, rsp_data}, 67'd0);
        @(negedge clock);
        reset = 1'b1;
        t = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (rsp_valid || busy) t++;
        end
        check("no_partial_rsp", 67'(t), 67'd0);
        run_op(3'b010, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 67'h2_0000_0003_0000_0007, 2);

        check("mosi_protocol", 67'(s_bad), 67'd0);
        check("fast_mosi_protocol", 67'(f_bad), 67'd0);
        check("scoreboard_empty", 67'(exp_q.size()), 67'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
